rocket_slot_arbiter: RTL and testbench

//  Shares a fixed pool of rocket slots (one rocket_move datapath per slot) among player and enemy tanks.

---
 rtl/rocket_pkg.sv | 28 ++
 rtl/rocket_rr_arbiter.sv | 70 +++++++
 rtl/rocket_slot_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_rocket_slot_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rocket_pkg.sv
// rocket_pkg
//  Shared types, default constants and width helpers for the rocket slot
//  arbiter and its round-robin/fixed-priority request arbiter.
package rocket_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        FLY     = 2'd2,
        EXPLODE = 2'd3
    } slot_state_t;

    localparam int DEF_NUM_TANKS       = 4;
    localparam int DEF_NUM_SLOTS       = 2;
    localparam int DEF_COOLDOWN_FRAMES = 15;
    localparam int DEF_EXPLODE_FRAMES  = 8;

    // Width of a tank index; a single tank still needs one bit.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n.
    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/rocket_rr_arbiter.sv
// rocket_rr_arbiter
//  Picks one requester out of a request vector.
//  Policy is selected at build time by macro ROCKET_RR_ARB_EN:
//   defined   -> round-robin, pointer moves to granted index + 1 when 'advance' is high
//   undefined -> fixed priority, lowest index wins (no clock, no state)
// Ports
//  clk, resetN  clock / async active-low reset (round-robin build only)
//  advance      grant was consumed this cycle (round-robin build only)
//  req          request vector
//  grant        one-hot grant (zero when no request)
//  grant_idx    index of the granted requester
//  grant_valid  at least one request present
module rocket_rr_arbiter #(
    parameter int NUM_TANKS = 4,
    parameter int OW        = 2
) (
`ifdef ROCKET_RR_ARB_EN
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 advance,
`endif
    input  logic [NUM_TANKS-1:0] req,
    output logic [NUM_TANKS-1:0] grant,
    output logic [OW-1:0]        grant_idx,
    output logic                 grant_valid
);

`ifdef ROCKET_RR_ARB_EN
    logic [OW-1:0] ptr_q;

    // Walk from the pointer upward; iterating downward lets the closest
    // requester after the pointer overwrite any farther one.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_TANKS - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_TANKS;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = OW'(idx);
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            ptr_q <= '0;
        else if (advance && grant_valid)
            ptr_q <= (grant_idx == OW'(NUM_TANKS - 1)) ? '0 : grant_idx + 1'b1;
    end
`else
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_TANKS - 1; k >= 0; k--) begin
            if (req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = OW'(k);
            end
        end
        if (grant_valid) grant[grant_idx] = 1'b1;
    end
`endif

endmodule

// File: rtl/rocket_slot_arbiter.sv
// rocket_slot_arbiter
//  Shares a pool of rocket datapaths among tanks: arbitrates shoot requests
//  once per frame, keeps one rocket in flight per tank plus a reload
//  cooldown, and sequences each slot through launch, flight, explosion and
//  release. Arbitration policy macro: ROCKET_RR_ARB_EN (round-robin when
//  defined, fixed lowest-index priority otherwise).
//
//  state   | meaning
//  IDLE    | slot free, slot_owner holds last owner
//  LAUNCH  | one clock, slot_launch pulses to the mover
//  FLY     | rocket moving, waiting for slot_hit or owner death
//  EXPLODE | explosion sprite, counts EXPLODE_FRAMES frames
//
// Ports
//  clk, resetN    clock / async active-low reset
//  startOfFrame   one-cycle pulse per frame
//  shoot_req      level request per tank
//  tank_dead      level, tank destroyed
//  slot_hit       pulse, slot's rocket collided or left the frame
//  shoot_grant    one-cycle pulse to the granted tank
//  slot_launch    pulse to the slot mover's shoot input
//  slot_owner     owning tank index per slot
//  slot_active    slot in LAUNCH or FLY
//  slot_explode   slot in EXPLODE
//  slot_kill      pulse forcing mover reset when the owner dies
module rocket_slot_arbiter
    import rocket_pkg::*;
#(
    parameter int NUM_TANKS       = DEF_NUM_TANKS,
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int EXPLODE_FRAMES  = DEF_EXPLODE_FRAMES
) (
    input  logic                                              clk,
    input  logic                                              resetN,
    input  logic                                              startOfFrame,
    input  logic [NUM_TANKS-1:0]                              shoot_req,
    input  logic [NUM_TANKS-1:0]                              tank_dead,
    input  logic [NUM_SLOTS-1:0]                              slot_hit,
    output logic [NUM_TANKS-1:0]                              shoot_grant,
    output logic [NUM_SLOTS-1:0]                              slot_launch,
    output logic [NUM_SLOTS-1:0][owner_width(NUM_TANKS)-1:0]  slot_owner,
    output logic [NUM_SLOTS-1:0]                              slot_active,
    output logic [NUM_SLOTS-1:0]                              slot_explode,
    output logic [NUM_SLOTS-1:0]                              slot_kill
);

    localparam int OW = owner_width(NUM_TANKS);
    localparam int CW = count_width(COOLDOWN_FRAMES);
    localparam int EW = count_width(EXPLODE_FRAMES);

    slot_state_t state_q [NUM_SLOTS];
    slot_state_t state_d [NUM_SLOTS];
    logic [OW-1:0] owner_d [NUM_SLOTS];
    logic [EW-1:0] ecnt_q  [NUM_SLOTS];
    logic [EW-1:0] ecnt_d  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] release_s;

    logic [NUM_TANKS-1:0] in_flight_q;
    logic [CW-1:0]        cooldown_q [NUM_TANKS];
    logic [NUM_TANKS-1:0] cd_zero, eligible, arb_grant, rel_tank, rel_load;
    logic [OW-1:0]        arb_idx;
    logic                 arb_valid, free_found, do_grant;
    int                   free_idx;

    always_comb begin
        free_found = 1'b0;
        free_idx   = 0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (state_q[s] == IDLE) begin
                free_found = 1'b1;
                free_idx   = s;
            end
        end
    end

    always_comb begin
        cd_zero = '0;
        for (int t = 0; t < NUM_TANKS; t++) cd_zero[t] = (cooldown_q[t] == '0);
        eligible = shoot_req & ~tank_dead & ~in_flight_q & cd_zero;
    end

    rocket_rr_arbiter #(
        .NUM_TANKS (NUM_TANKS),
        .OW        (OW)
    ) u_arb (
`ifdef ROCKET_RR_ARB_EN
        .clk         (clk),
        .resetN      (resetN),
        .advance     (do_grant),
`endif
        .req         (eligible),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign do_grant    = startOfFrame && free_found && arb_valid;
    assign shoot_grant = do_grant ? arb_grant : '0;

    // Slot next-state; owner death beats a same-cycle hit.
    always_comb begin
        slot_kill = '0;
        release_s = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_d[s] = state_q[s];
            owner_d[s] = slot_owner[s];
            ecnt_d[s]  = ecnt_q[s];
            case (state_q[s])
                IDLE: begin
                    if (do_grant && (free_idx == s)) begin
                        state_d[s] = LAUNCH;
                        owner_d[s] = arb_idx;
                    end
                end
                LAUNCH, FLY: begin
                    if (tank_dead[slot_owner[s]]) begin
                        state_d[s]   = IDLE;
                        slot_kill[s] = 1'b1;
                        release_s[s] = 1'b1;
                    end else if (state_q[s] == LAUNCH) begin
                        state_d[s] = FLY;
                    end else if (slot_hit[s]) begin
                        state_d[s] = EXPLODE;
                        ecnt_d[s]  = EW'(EXPLODE_FRAMES);
                    end
                end
                EXPLODE: begin
                    if (startOfFrame) begin
                        if (ecnt_q[s] <= EW'(1)) begin
                            state_d[s]   = IDLE;
                            release_s[s] = 1'b1;
                        end else begin
                            ecnt_d[s] = ecnt_q[s] - 1'b1;
                        end
                    end
                end
                default: state_d[s] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s]    <= IDLE;
                slot_owner[s] <= '0;
                ecnt_q[s]     <= '0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s]    <= state_d[s];
                slot_owner[s] <= owner_d[s];
                ecnt_q[s]     <= ecnt_d[s];
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_launch[s]  = (state_q[s] == LAUNCH);
            slot_active[s]  = (state_q[s] == LAUNCH) || (state_q[s] == FLY);
            slot_explode[s] = (state_q[s] == EXPLODE);
        end
    end

    // Map slot releases onto their owners; a death release skips the reload.
    always_comb begin
        rel_tank = '0;
        rel_load = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (release_s[s]) begin
                rel_tank[slot_owner[s]] = 1'b1;
                if (!slot_kill[s]) rel_load[slot_owner[s]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            in_flight_q <= '0;
            for (int t = 0; t < NUM_TANKS; t++) cooldown_q[t] <= '0;
        end else begin
            for (int t = 0; t < NUM_TANKS; t++) begin
                if (shoot_grant[t])
                    in_flight_q[t] <= 1'b1;
                else if (rel_tank[t])
                    in_flight_q[t] <= 1'b0;

                if (rel_load[t])
                    cooldown_q[t] <= CW'(COOLDOWN_FRAMES);
                else if (rel_tank[t])
                    cooldown_q[t] <= '0;
                else if (startOfFrame && !cd_zero[t])
                    cooldown_q[t] <= cooldown_q[t] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rocket_slot_arbiter.sv
// tb_rocket_slot_arbiter
//  Directed bench for rocket_slot_arbiter with default parameters
//  (4 tanks, 2 slots, cooldown 15 frames, explosion 8 frames).
//  Follows ROCKET_RR_ARB_EN for the expected arbitration order.
module tb_rocket_slot_arbiter;

    logic             clk = 1'b0;
    logic             resetN = 1'b0;
    logic             startOfFrame = 1'b0;
    logic [3:0]       shoot_req = '0;
    logic [3:0]       tank_dead = '0;
    logic [1:0]       slot_hit = '0;
    logic [3:0]       shoot_grant;
    logic [1:0]       slot_launch;
    logic [1:0][1:0]  slot_owner;
    logic [1:0]       slot_active;
    logic [1:0]       slot_explode;
    logic [1:0]       slot_kill;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rocket_slot_arbiter dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .shoot_req    (shoot_req),
        .tank_dead    (tank_dead),
        .slot_hit     (slot_hit),
        .shoot_grant  (shoot_grant),
        .slot_launch  (slot_launch),
        .slot_owner   (slot_owner),
        .slot_active  (slot_active),
        .slot_explode (slot_explode),
        .slot_kill    (slot_kill)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sof_grant(input logic [3:0] exp, input string tag);
        startOfFrame = 1'b1;
        #1;
        chk(tag, shoot_grant, exp);
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    int n_early;
    int exp_idx [4];

    initial begin
`ifdef ROCKET_RR_ARB_EN
        exp_idx = '{0, 1, 2, 3};
`else
        exp_idx = '{0, 0, 0, 0};
`endif
        // reset state
        step(); step();
        chk("reset_outputs", {shoot_grant, slot_launch, slot_owner, slot_active, slot_explode, slot_kill}, 0);
        resetN = 1'b1;
        step();

        // single request from the player
        shoot_req = 4'b0001;
        sof_grant(4'b0001, "t2_grant");
        chk("t2_launch", slot_launch, 2'b01);
        chk("t2_owner0", slot_owner[0], 0);
        chk("t2_active", slot_active, 2'b01);
        step();
        chk("t2_fly_launch_low", slot_launch, 2'b00);
        chk("t2_fly_active", slot_active, 2'b01);

        // reset while flying
        resetN = 1'b0;
        step(); step();
        chk("t1_reset_outputs", {shoot_grant, slot_launch, slot_owner, slot_active, slot_explode, slot_kill}, 0);
        resetN = 1'b1;
        step();
        sof_grant(4'b0001, "t1_regrant");
        chk("t1_launch", slot_launch, 2'b01);
        step();

        // hit -> explosion for 8 frames -> cooldown of 15 frames
        shoot_req = 4'b0000;
        slot_hit = 2'b01;
        step();
        slot_hit = 2'b00;
        chk("t3_explode_start", slot_explode, 2'b01);
        chk("t3_inactive", slot_active, 2'b00);
        repeat (7) frame();
        chk("t3_explode_after7", slot_explode, 2'b01);
        frame();
        chk("t3_explode_done", slot_explode, 2'b00);
        chk("t3_idle", slot_active, 2'b00);
        shoot_req = 4'b0001;
        n_early = 0;
        repeat (15) begin
            startOfFrame = 1'b1;
            #1;
            if (shoot_grant != 4'b0000) n_early++;
            step();
            startOfFrame = 1'b0;
            step();
        end
        chk("t3_cooldown_hold", n_early, 0);
        sof_grant(4'b0001, "t3_cooldown_expire");
        step();

        // both slots busy
        shoot_req = 4'b0011;
        sof_grant(4'b0010, "t4_second_slot");
        chk("t4_owner1", slot_owner[1], 1);
        chk("t4_launch1", slot_launch, 2'b10);
        step();
        shoot_req = 4'b0101;
        sof_grant(4'b0000, "t4_full_a");
        step();
        sof_grant(4'b0000, "t4_full_b");

        // owner death with simultaneous hit
        tank_dead = 4'b0010;
        slot_hit = 2'b10;
        #1;
        chk("t5_kill_pulse", slot_kill, 2'b10);
        step();
        tank_dead = 4'b0000;
        slot_hit = 2'b00;
        chk("t5_no_explode", slot_explode, 2'b00);
        chk("t5_active", slot_active, 2'b01);
        chk("t5_kill_low", slot_kill, 2'b00);
        sof_grant(4'b0100, "t4_after_free");
        chk("t4_owner1_tank2", slot_owner[1], 2);
        step();
        tank_dead = 4'b0001;
        #1;
        chk("t5_kill_slot0", slot_kill, 2'b01);
        step();
        tank_dead = 4'b0000;
        shoot_req = 4'b0010;
        sof_grant(4'b0010, "t5_no_cooldown");
        chk("t5_owner0_tank1", slot_owner[0], 1);

        // arbitration order with all tanks requesting
        resetN = 1'b0;
        step(); step();
        resetN = 1'b1;
        step();
        shoot_req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            sof_grant(4'(1 << exp_idx[i]), $sformatf("t6_grant%0d", i));
            chk($sformatf("t6_owner%0d", i), slot_owner[0], exp_idx[i]);
            tank_dead = 4'(1 << exp_idx[i]);
            step();
            tank_dead = 4'b0000;
            chk($sformatf("t6_freed%0d", i), slot_active, 2'b00);
            chk($sformatf("t6_owner_hold%0d", i), slot_owner[0], exp_idx[i]);
        end

        // dead tank cannot fire
        shoot_req = 4'b0001;
        tank_dead = 4'b0001;
        sof_grant(4'b0000, "dead_mask");
        tank_dead = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
